// File: rtl/ahb_cmd_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
//   Shared definitions for the AHB command FIFO slave: HTRANS encodings,
//   register offsets decoded from HADDR[3:2], STATUS field positions and a
//   helper that packs the STATUS word.
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } regSel_e;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_COUNT_LSB = 2;
  localparam int STAT_COUNT_W   = 14;

  // STATUS = {16'h0, count (14 bits), full, empty}
  function automatic logic [31:0] packStatus(input logic [STAT_COUNT_W-1:0] count,
                                             input logic full,
                                             input logic empty);
    logic [31:0] s;
    s = '0;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_FULL_BIT]  = full;
    s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    return s;
  endfunction

endpackage

// File: rtl/ahb_cmd_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with a registered storage array and a combinational
//   head read, so the head word is visible the cycle after it is written.
//
//   Ports:
//     HCLK, HRESETn    clock, asynchronous active-low reset
//     i_push, i_din    write a word (ignored when full)
//     i_pop            drop the head word (ignored when empty)
//     i_flush          empty the FIFO; overrides push and pop
//     o_dout           head word, 0 while empty
//     o_full, o_empty  occupancy flags
//     o_count          number of stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  logic w_doPush;
  logic w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  // Forcing the head to 0 while empty gives a clean 0 on the stream after reset
  assign o_dout   = o_empty ? '0 : r_mem[r_rdPtr];

  assign w_doPush = i_push & ~o_full  & ~i_flush;
  assign w_doPop  = i_pop  & ~o_empty & ~i_flush;

  // Storage carries no reset; the empty mask above hides stale contents
  always_ff @(posedge HCLK) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ahb_cmd_fifo.sv
// ---------------------------------------------------------------------------
// ahb_cmd_fifo
//   AHB-Lite slave that buffers 32-bit command words for the vector graphics
//   core. Writes to DATA push into a FIFO, the core drains it through a
//   valid/ready stream, and a write to DATA while full is held with wait
//   states rather than dropped.
//
//   Ports:
//     HCLK, HRESETn            bus clock, asynchronous active-low reset
//     HSEL, HADDR, HTRANS,
//     HWRITE, HSIZE, HWDATA,
//     HREADY                   AHB-Lite slave inputs (HSIZE unused)
//     HREADYOUT, HRDATA        AHB-Lite slave outputs
//     cmd_valid, cmd_data      head of FIFO toward the core
//     cmd_ready                core accepts the head word
// ---------------------------------------------------------------------------
module ahb_cmd_fifo
  import ahb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        cmd_valid,
  output logic [31:0] cmd_data,
  input  logic        cmd_ready
);

  logic    r_wrPend;
  logic    r_rdPend;
  regSel_e r_regSel;

  logic          w_accept;
  logic          w_push;
  logic          w_flush;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_unused;

  assign w_unused = ^{HSIZE, HADDR[31:4], HADDR[1:0]};

  assign w_accept = HSEL & HREADY &
                    ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  // Address-phase capture. The pipeline only advances when HREADY is high;
  // while the bus is stalled the pending data phase must be held, otherwise
  // a write stalled on a full FIFO would be lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wrPend <= 1'b0;
      r_rdPend <= 1'b0;
      r_regSel <= REG_DATA;
    end else if (HREADY) begin
      r_wrPend <= w_accept &  HWRITE;
      r_rdPend <= w_accept & ~HWRITE;
      if (w_accept) begin
        r_regSel <= regSel_e'(HADDR[3:2]);
      end
    end
  end

  // Stall only a DATA write that finds the FIFO full; registered state only,
  // so the stall releases the cycle after a pop clears full
  assign HREADYOUT = ~(r_wrPend & (r_regSel == REG_DATA) & w_full);

  // Data-phase actions fire on the edge that ends the data phase
  assign w_push  = r_wrPend & (r_regSel == REG_DATA) & ~w_full & HREADY;
  assign w_flush = r_wrPend & (r_regSel == REG_CTRL) & HWDATA[0] & HREADY;

  always_comb begin
    HRDATA = '0;
    if (r_rdPend && (r_regSel == REG_STATUS)) begin
      HRDATA = packStatus(STAT_COUNT_W'(w_count), w_full, w_empty);
    end
  end

  assign cmd_valid = ~w_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .i_push  (w_push),
    .i_pop   (cmd_ready),
    .i_flush (w_flush),
    .i_din   (HWDATA),
    .o_dout  (cmd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_ahb_cmd_fifo.sv
// ---------------------------------------------------------------------------
// tb_ahb_cmd_fifo
//   Self-checking bench for ahb_cmd_fifo. Words written to DATA are queued
//   as expected stream output; a stream monitor pops and compares them as
//   the core side accepts them.
// ---------------------------------------------------------------------------
module tb_ahb_cmd_fifo;
  import ahb_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HWDATA = '0;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready = 1'b0;
  logic        hreadyEn = 1'b1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] wrBuf[$];
  logic [31:0] expWord;
  logic [31:0] rdVal;

  logic        watch = 1'b0;
  int          maxCount;
  int          stallCycles;

  always #5 HCLK = ~HCLK;

  // Interconnect model: global HREADY follows this slave unless a test
  // forces it low to mimic another slave stalling the bus
  assign HREADY = HREADYOUT & hreadyEn;

  ahb_cmd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready)
  );

  // Stream monitor: every accepted head word must match the scoreboard head
  always @(negedge HCLK) begin
    if (HRESETn && cmd_valid && cmd_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL stream_unexpected: got %h, required no word", cmd_data);
      end else begin
        expWord = expQ.pop_front();
        if (cmd_data !== expWord) begin
          errors++;
          $display("[TB] FAIL stream_order: got %h, required %h", cmd_data, expWord);
        end
      end
    end
  end

  // Observation of occupancy and stalls during the back-to-back burst
  always @(negedge HCLK) begin
    if (watch) begin
      if (int'(u_dut.u_fifo.o_count) > maxCount) maxCount = int'(u_dut.u_fifo.o_count);
      if (!HREADYOUT) stallCycles++;
    end
  end

  // Advance one edge at which HREADY is high, with a bounded wait
  task automatic waitReady(input string name);
    int n;
    n = 0;
    @(negedge HCLK);
    while (!HREADY && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    if (!HREADY) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: HREADY got %b, required 1", name, HREADY);
    end
    @(posedge HCLK);
    #1;
  endtask

  // Pipelined write burst of wrBuf to one address
  task automatic ahbWrites(input logic [31:0] addr);
    int n;
    n = wrBuf.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HSEL   = 1'b1;
        HTRANS = (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        HWRITE = 1'b1;
        HADDR  = addr;
        if (addr[3:2] == REG_DATA) expQ.push_back(wrBuf[i]);
      end else begin
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
      end
      if (i > 0) HWDATA = wrBuf[i-1];
      waitReady("write");
    end
  endtask

  task automatic ahbRead(input logic [31:0] addr, output logic [31:0] data);
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HWRITE = 1'b0;
    HADDR  = addr;
    waitReady("read_addr");
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    data = HRDATA;
    @(posedge HCLK);
    #1;
  endtask

  task automatic readStatus(input string name, input logic [31:0] expected);
    ahbRead(32'h4, rdVal);
    checks++;
    if (rdVal !== expected) begin
      errors++;
      $display("[TB] FAIL %s: STATUS got %h, required %h", name, rdVal, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic required);
    checks++;
    if (got !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %b, required %b", name, got, required);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    cmd_ready = 1'b1;
    while (expQ.size() != 0 && n < 40) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    cmd_ready = 1'b0;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: words left got %0d, required 0", name, expQ.size());
    end
    checkBit({name, "_valid_after"}, cmd_valid, 1'b0);
  endtask

  task automatic stallOnNinth(input logic [31:0] word, input logic expectWord);
    wrBuf.delete();
    for (int i = 0; i < DEPTH; i++) wrBuf.push_back(32'h100 + i);
    ahbWrites(32'h0);
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HWRITE = 1'b1;
    HADDR  = 32'h0;
    if (expectWord) expQ.push_back(word);
    waitReady("ninth_addr");
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HWDATA = word;
  endtask

  task automatic test_reset();
    cmd_ready = 1'b0;
    stallOnNinth(32'h55, 1'b0);
    repeat (3) @(posedge HCLK);
    #1;
    checkBit("reset_prestall", HREADYOUT, 1'b0);
    HRESETn = 1'b0;
    #1;
    checkBit("reset_hreadyout", HREADYOUT, 1'b1);
    checkBit("reset_valid", cmd_valid, 1'b0);
    checks++;
    if (cmd_data !== 32'h0 || HRDATA !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: cmd_data got %h HRDATA got %h, required 0 and 0", cmd_data, HRDATA);
    end
    expQ.delete();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    readStatus("reset_status", 32'h0000_0001);
  endtask

  task automatic test_basic_stream();
    cmd_ready = 1'b0;
    wrBuf = '{32'hA1, 32'hB2, 32'hC3};
    ahbWrites(32'h0);
    checkBit("basic_valid", cmd_valid, 1'b1);
    checks++;
    if (cmd_data !== 32'hA1) begin
      errors++;
      $display("[TB] FAIL basic_head: got %h, required %h", cmd_data, 32'hA1);
    end
    readStatus("basic_status", 32'h0000_000C);
    drain("basic");
  endtask

  task automatic test_full_stall();
    cmd_ready = 1'b0;
    stallOnNinth(32'h99, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      checkBit("stall_hold", HREADYOUT, 1'b0);
    end
    @(posedge HCLK);
    #1;
    cmd_ready = 1'b1;
    @(posedge HCLK);
    #1;
    cmd_ready = 1'b0;
    checkBit("stall_release", HREADYOUT, 1'b1);
    waitReady("stall_push");
    readStatus("stall_status", 32'h0000_0022);
    drain("stall");
  endtask

  task automatic test_flush();
    cmd_ready = 1'b0;
    wrBuf = '{32'h11, 32'h22, 32'h33, 32'h44};
    ahbWrites(32'h0);
    readStatus("flush_pre", 32'h0000_0010);
    wrBuf = '{32'h1};
    ahbWrites(32'h8);
    checkBit("flush_valid", cmd_valid, 1'b0);
    expQ.delete();
    readStatus("flush_status", 32'h0000_0001);
  endtask

  task automatic rawCycle(input logic sel, input logic [1:0] trans, input logic en,
                          input logic [31:0] data);
    HSEL     = sel;
    HTRANS   = trans;
    HWRITE   = 1'b1;
    HADDR    = 32'h0;
    hreadyEn = en;
    @(posedge HCLK);
    #1;
    hreadyEn = 1'b1;
    HSEL     = 1'b0;
    HTRANS   = HTRANS_IDLE;
    HWRITE   = 1'b0;
    HWDATA   = data;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_ignored();
    cmd_ready = 1'b0;
    wrBuf = '{32'h77};
    ahbWrites(32'h0);
    rawCycle(1'b1, HTRANS_IDLE,   1'b1, 32'hDEAD_0001);
    rawCycle(1'b0, HTRANS_NONSEQ, 1'b1, 32'hDEAD_0002);
    rawCycle(1'b1, HTRANS_NONSEQ, 1'b0, 32'hDEAD_0003);
    readStatus("ignored_transfers", 32'h0000_0004);
    wrBuf = '{32'h1};
    ahbWrites(32'hC);
    ahbWrites(32'h4);
    readStatus("ignored_regs", 32'h0000_0004);
    checks++;
    if (cmd_data !== 32'h77) begin
      errors++;
      $display("[TB] FAIL ignored_head: got %h, required %h", cmd_data, 32'h77);
    end
    drain("ignored");
  endtask

  task automatic test_back_to_back();
    wrBuf.delete();
    for (int i = 0; i < 20; i++) wrBuf.push_back(32'h2000 + i * 32'h11);
    maxCount    = 0;
    stallCycles = 0;
    cmd_ready   = 1'b1;
    watch       = 1'b1;
    ahbWrites(32'h0);
    drain("b2b");
    watch = 1'b0;
    checks++;
    if (stallCycles != 0) begin
      errors++;
      $display("[TB] FAIL b2b_stall: stall cycles got %0d, required 0", stallCycles);
    end
    checks++;
    if (maxCount > 1) begin
      errors++;
      $display("[TB] FAIL b2b_count: max count got %0d, required <= 1", maxCount);
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    readStatus("initial_status", 32'h0000_0001);
    test_reset();
    test_basic_stream();
    test_full_stall();
    test_flush();
    test_ignored();
    test_back_to_back();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL final_queue: words left got %0d, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
